// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave interface: mode encodings, FSM states
// and the default frame width.
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with registered
// rise/fall pulses taken against a history flop.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave: synchronises SCK/CS_N/MOSI, deserialises MOSI into words and
// serialises MISO from a one-entry transmit holding register.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              sck_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              underrun_o,
    output logic              busy_o
);

    localparam int unsigned          CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_W - 1);

    spi_state_e             state_q, state_d;
    spi_mode_t              mode_q;
    logic [DATA_W-1:0]      hold_q;
    logic                   hold_full_q;
    logic [DATA_W-1:0]      tx_shift_q;
    logic [DATA_W-1:0]      rx_shift_q;
    logic [DATA_W-1:0]      rx_data_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic                   rx_valid_q;
    logic                   underrun_q;
    logic [SYNC_STAGES-1:0] mosi_q;

    logic sck_sync_unused;
    logic sck_rise, sck_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic mosi_s;
    logic lead_edge, trail_edge, in_frame;
    logic sample_evt, shift_evt, load_evt, frame_end, last_bit;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   (sck_i),
        .sync_o    (sck_sync_unused),
        .rise_o    (sck_rise),
        .fall_o    (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   (cs_n_i),
        .sync_o    (cs_n_s),
        .rise_o    (cs_rise),
        .fall_o    (cs_fall)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
        end
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // Leading edge leaves the idle level; an edge alongside CS rise is dropped.
    assign lead_edge  = mode_q.cpol ? sck_fall : sck_rise;
    assign trail_edge = mode_q.cpol ? sck_rise : sck_fall;
    assign in_frame   = (state_q == ACTIVE) && !cs_rise;
    assign sample_evt = in_frame && (mode_q.cpha ? trail_edge : lead_edge);
    assign shift_evt  = in_frame && (mode_q.cpha ? lead_edge : trail_edge);
    assign last_bit   = (bit_cnt_q == LAST_BIT);
    assign frame_end  = (state_q == ACTIVE) && cs_rise;
    assign load_evt   = ((state_q == IDLE) && cs_fall && !mode_q.cpha)
                      || (sample_evt && last_bit && !mode_q.cpha)
                      || (shift_evt && (bit_cnt_q == '0) && mode_q.cpha);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        miso_o     = 1'b0;
        miso_oe_o  = !cs_n_s;
        busy_o     = !cs_n_s;
        tx_ready_o = !hold_full_q;
        rx_data_o  = rx_data_q;
        rx_valid_o = rx_valid_q;
        underrun_o = underrun_q;
        if (state_q == ACTIVE) begin
            miso_o = tx_shift_q[DATA_W-1];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mode_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            if (cs_n_s) begin
                mode_q <= '{cpol: cpol_i, cpha: cpha_i};
            end

            if (frame_end) begin
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
                tx_shift_q <= '0;
            end else if (sample_evt) begin
                rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
                if (last_bit) begin
                    bit_cnt_q  <= '0;
                    rx_data_q  <= {rx_shift_q[DATA_W-2:0], mosi_s};
                    rx_valid_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
            end else if (shift_evt && (bit_cnt_q != '0)) begin
                tx_shift_q <= tx_shift_q << 1;
            end

            // Load drains the old holding word first; a same-cycle handshake refills it.
            if (load_evt) begin
                tx_shift_q  <= hold_full_q ? hold_q : '0;
                underrun_q  <= !hold_full_q;
                hold_full_q <= 1'b0;
            end
            if (tx_valid_i && !hold_full_q) begin
                hold_q      <= tx_data_i;
                hold_full_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: a behavioural SPI master plus a
// word-level model of frame loads, received words and underruns.
module tb_spi_slave_if;
    import spi_pkg::*;

    localparam int unsigned DW   = SPI_DATA_W;
    localparam int unsigned SYNC = 2;
    localparam int unsigned HALF = 8;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          cpol_i, cpha_i, sck_i, cs_n_i, mosi_i;
    logic          miso_o, miso_oe_o, tx_ready_o, rx_valid_o, underrun_o, busy_o;
    logic          tx_valid_i;
    logic [DW-1:0] tx_data_i, rx_data_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  rx_got[$];
    int unsigned under_cnt = 0;
    logic [7:0]  mi, m1, m2;

    always #5 clk_i = ~clk_i;

    spi_slave_if #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .cpol_i     (cpol_i),
        .cpha_i     (cpha_i),
        .sck_i      (sck_i),
        .cs_n_i     (cs_n_i),
        .mosi_i     (mosi_i),
        .miso_o     (miso_o),
        .miso_oe_o  (miso_oe_o),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .underrun_o (underrun_o),
        .busy_o     (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (reset_n_i) begin
            if (rx_valid_o) rx_got.push_back(rx_data_o);
            if (underrun_o) under_cnt++;
        end
    end

    task automatic clks(input int unsigned n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push(input logic [7:0] w);
        int unsigned t = 0;
        while (!tx_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        check("push_ready", 32'(tx_ready_o), 32'd1);
        tx_data_i  = w;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        cpol_i = m[1];
        cpha_i = m[0];
        sck_i  = m[1];
        clks(6);
    endtask

    task automatic cs_start();
        cs_n_i = 1'b0;
        clks(HALF);
    endtask

    task automatic cs_end();
        clks(HALF);
        cs_n_i = 1'b1;
        clks(HALF);
    endtask

    // Master: drives MOSI MSB first, samples MISO on the master's sample edge.
    task automatic xfer(input logic [7:0] mo, input int unsigned nbits, output logic [7:0] mo_seen);
        logic [7:0] acc = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            if (!cpha_i) begin
                mosi_i = mo[7-i];
                clks(HALF);
                sck_i = ~cpol_i;
                acc   = {acc[6:0], miso_o};
                clks(HALF);
                sck_i = cpol_i;
            end else begin
                sck_i  = ~cpol_i;
                mosi_i = mo[7-i];
                clks(HALF);
                sck_i = cpol_i;
                acc   = {acc[6:0], miso_o};
                clks(HALF);
            end
        end
        mo_seen = acc;
    endtask

    task automatic expect_rx(input string tag, input int unsigned n, input logic [7:0] e0,
                             input logic [7:0] e1, input int unsigned exp_under);
        check({tag, "_cnt"}, 32'(rx_got.size()), 32'(n));
        if (n > 0 && rx_got.size() > 0) check({tag, "_rx0"}, 32'(rx_got[0]), 32'(e0));
        if (n > 1 && rx_got.size() > 1) check({tag, "_rx1"}, 32'(rx_got[1]), 32'(e1));
        check({tag, "_under"}, 32'(under_cnt), 32'(exp_under));
        rx_got.delete();
        under_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},    32'(miso_o),     32'd0);
        check({tag, "_oe"},      32'(miso_oe_o),  32'd0);
        check({tag, "_ready"},   32'(tx_ready_o), 32'd1);
        check({tag, "_rxdata"},  32'(rx_data_o),  32'd0);
        check({tag, "_rxvalid"}, 32'(rx_valid_o), 32'd0);
        check({tag, "_under"},   32'(underrun_o), 32'd0);
        check({tag, "_busy"},    32'(busy_o),     32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  m;
        logic [7:0]  mo, w;
        logic        do_push;
        int unsigned exp_under;

        reset_n_i  = 1'b0;
        cpol_i     = 1'b0;
        cpha_i     = 1'b0;
        sck_i      = 1'b0;
        cs_n_i     = 1'b1;
        mosi_i     = 1'b0;
        tx_valid_i = 1'b0;
        tx_data_i  = '0;
        clks(3);
        check_reset_outputs("rst");
        reset_n_i = 1'b1;
        clks(5);

        // Mode 0 single byte; end-of-byte reload finds the holding register empty.
        set_mode(2'd0);
        push(8'h3C);
        cs_start();
        check("t1_ready_after_cs", 32'(tx_ready_o), 32'd1);
        check("t1_busy", 32'(busy_o), 32'd1);
        check("t1_oe", 32'(miso_oe_o), 32'd1);
        xfer(8'hA5, 8, mi);
        cs_end();
        check("t1_miso_word", 32'(mi), 32'h3C);
        check("t1_busy_end", 32'(busy_o), 32'd0);
        expect_rx("t1", 1, 8'hA5, 8'h00, 1);

        // Mode 3 single byte; cpha=1 loads once per byte.
        set_mode(2'd3);
        push(8'h81);
        cs_start();
        xfer(8'h5A, 8, mi);
        cs_end();
        check("t2_miso_word", 32'(mi), 32'h81);
        expect_rx("t2", 1, 8'h5A, 8'h00, 0);

        // Mode 0 two bytes, refilling during each byte.
        set_mode(2'd0);
        push(8'h11);
        cs_start();
        fork
            xfer(8'hF0, 8, m1);
            begin clks(30); push(8'h22); end
        join
        fork
            xfer(8'h0F, 8, m2);
            begin clks(30); push(8'h33); end
        join
        cs_end();
        check("t3_miso0", 32'(m1), 32'h11);
        check("t3_miso1", 32'(m2), 32'h22);
        expect_rx("t3", 2, 8'hF0, 8'h0F, 0);

        // Mode 1 with empty holding register.
        set_mode(2'd1);
        cs_start();
        xfer(8'h3E, 8, mi);
        cs_end();
        check("t4_miso_word", 32'(mi), 32'h00);
        expect_rx("t4", 1, 8'h3E, 8'h00, 1);

        // Abort after 5 bits, then a full frame.
        set_mode(2'd0);
        push(8'h77);
        cs_start();
        xfer(8'hB4, 5, mi);
        cs_end();
        check("t5_partial_miso", 32'(mi), 32'h0E);
        check("t5_rxdata_held", 32'(rx_data_o), 32'h3E);
        expect_rx("t5a", 0, 8'h00, 8'h00, 0);
        push(8'h5E);
        cs_start();
        xfer(8'hC3, 8, mi);
        cs_end();
        check("t5_miso_word", 32'(mi), 32'h5E);
        expect_rx("t5b", 1, 8'hC3, 8'h00, 1);

        // Asynchronous reset mid-frame with a word waiting in the holding register.
        set_mode(2'd0);
        push(8'h69);
        cs_start();
        push(8'h42);
        xfer(8'hAA, 3, mi);
        check("t6_partial_miso", 32'(mi), 32'h03);
        reset_n_i = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        cs_n_i = 1'b1;
        sck_i  = 1'b0;
        mosi_i = 1'b0;
        clks(4);
        reset_n_i = 1'b1;
        clks(4);
        rx_got.delete();
        under_cnt = 0;
        push(8'hE7);
        cs_start();
        xfer(8'h96, 8, mi);
        cs_end();
        check("t6_miso_word", 32'(mi), 32'hE7);
        expect_rx("t6", 1, 8'h96, 8'h00, 1);

        // Random single-byte frames in random modes.
        for (int unsigned it = 0; it < 10; it++) begin
            m       = 2'($urandom_range(0, 3));
            mo      = 8'($urandom);
            w       = 8'($urandom);
            do_push = 1'($urandom_range(0, 1));
            set_mode(m);
            if (do_push) push(w);
            cs_start();
            xfer(mo, 8, mi);
            cs_end();
            // cpha=0 loads at CS fall and at byte end; cpha=1 loads once.
            exp_under = (m[0] ? 1 : 2) - (do_push ? 1 : 0);
            check("rnd_miso_word", 32'(mi), do_push ? 32'(w) : 32'd0);
            expect_rx("rnd", 1, mo, 8'h00, exp_under);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
